// File: rtl/seq_hd_serializer_if.sv
// Word-stream bus from the hard-decision serializer to the downstream sink.
// The master drives data/valid/last; the slave returns ready.
interface seq_hd_serializer_if #(
    parameter int W = 64
);
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_last;
    logic         dout_ready;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/seq_hd_serializer.sv
// Captures the final hard-decision codeword of a frame and streams it out
// as W-bit beats with a valid/ready handshake, tagged with iteration count.
module seq_hd_serializer #(
    parameter int N_BITS = 9216,
    parameter int W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] v_out,
    input  logic              f_one_iteration,
    input  logic              last_iteration,
    input  logic              converged,
    output logic [4:0]        dout_iter,
    output logic              dout_conv,
    output logic              stop_decode,
    output logic              busy,
    output logic              frame_drop,
    seq_hd_serializer_if.master dbus
);
    localparam int BEATS = N_BITS / W;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [4:0]        iter_cnt_q, iter_cnt_d;
    logic [N_BITS-1:0] shadow_q, shadow_d;
    logic [4:0]        dout_iter_q, dout_iter_d;
    logic              dout_conv_q, dout_conv_d;
    logic              stop_q, stop_d;
    logic              drop_q, drop_d;

    logic       trig;
    logic       send;
    logic       hs;
    logic [4:0] iter_inc;

    assign trig     = f_one_iteration && (converged || last_iteration);
    assign send     = (state_q == S_SEND);
    assign hs       = send && dbus.dout_ready;
    assign iter_inc = (iter_cnt_q == 5'd31) ? 5'd31 : iter_cnt_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        iter_cnt_d  = iter_cnt_q;
        shadow_d    = shadow_q;
        dout_iter_d = dout_iter_q;
        dout_conv_d = dout_conv_q;
        stop_d      = 1'b0;
        drop_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d     = S_ARM;
                    stop_d      = 1'b1;
                    dout_conv_d = converged;
                    dout_iter_d = iter_inc;
                    iter_cnt_d  = 5'd0;
                end else if (f_one_iteration) begin
                    iter_cnt_d = iter_inc;
                end
            end
            // v_out is registered upstream, so the codeword settles here
            S_ARM: begin
                shadow_d = v_out;
                beat_d   = '0;
                state_d  = S_SEND;
                drop_d   = trig;
            end
            S_SEND: begin
                drop_d = trig;
                if (hs) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            iter_cnt_q  <= '0;
            shadow_q    <= '0;
            dout_iter_q <= '0;
            dout_conv_q <= 1'b0;
            stop_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            iter_cnt_q  <= iter_cnt_d;
            shadow_q    <= shadow_d;
            dout_iter_q <= dout_iter_d;
            dout_conv_q <= dout_conv_d;
            stop_q      <= stop_d;
            drop_q      <= drop_d;
        end
    end

    assign dbus.dout_valid = send;
    assign dbus.dout       = send ? shadow_q[int'(beat_q) * W +: W] : '0;
    assign dbus.dout_last  = send && (beat_q == LAST_BEAT);
    assign dout_iter       = dout_iter_q;
    assign dout_conv       = dout_conv_q;
    assign stop_decode     = stop_q;
    assign frame_drop      = drop_q;
    assign busy            = (state_q != S_IDLE);
endmodule

// File: doc/seq_hd_serializer.md
SEQ_HD_SERIALIZER -- requirements
Module: seq_hd_serializer

Interface
REQ-001 SHALL have parameter N_BITS, 9216, hard-decision codeword length.
REQ-002 SHALL have parameter W, 64, output word width; N_BITS/W = 144 beats.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port v_out  input  9216  registered hard decisions from q-update stage (valid the cycle after f_one_iteration).
REQ-006 SHALL have port f_one_iteration  input  1  one-cycle pulse, iteration complete.
REQ-007 SHALL have port last_iteration  input  1  level, current iteration is the final allowed one.
REQ-008 SHALL have port converged  input  1  level, all parity checks satisfied; sampled with f_one_iteration.
REQ-009 SHALL have port dout_ready  input  1  downstream accepts word.
REQ-010 SHALL have port dout  output  64  codeword word, beat k = v_out[k*64 +: 64].
REQ-011 SHALL have port dout_valid  output  1  dout holds valid word.
REQ-012 SHALL have port dout_last  output  1  high with beat 143.
REQ-013 SHALL have port dout_iter  output  5  iterations used for this frame, stable while busy.
REQ-014 SHALL have port dout_conv  output  1  frame terminated by convergence.
REQ-015 SHALL have port stop_decode  output  1  one-cycle pulse to decoder controller, frame terminated.
REQ-016 SHALL have port busy  output  1  high in ARM or SEND.
REQ-017 SHALL have port frame_drop  output  1  one-cycle pulse, termination lost because busy.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, SEND.
REQ-019 Trigger SHALL be f_one_iteration && (converged || last_iteration).
REQ-020 IDLE + trigger SHALL go to ARM next cycle, pulse stop_decode same cycle as trigger registered (one cycle after trigger), latch dout_conv <= converged, dout_iter <= iter_cnt+1 saturating at 31.
REQ-021 ARM SHALL capture v_out into a 9216-bit shadow register, clear beat counter, go to SEND next cycle (compensates one-cycle v_out register latency).
REQ-022 SEND SHALL assert dout_valid, drive dout from shadow at current beat; dout_last = (beat==143).
REQ-023 Beat SHALL advance only on dout_valid && dout_ready; dout, dout_last stable while valid && !ready.
REQ-024 Handshake on beat 143 SHALL return to IDLE next cycle with dout_valid low; no idle bubble required beyond that cycle.
REQ-025 First dout_valid SHALL appear 2 cycles after trigger cycle; with dout_ready held high, frame occupies 144 consecutive cycles.
REQ-026 iter_cnt (5 bits) SHALL increment on every f_one_iteration in IDLE, saturate at 31, clear to 0 on trigger.
REQ-027 Trigger while ARM or SEND SHALL be ignored for capture, shall not alter shadow/dout_iter/dout_conv, and SHALL pulse frame_drop next cycle; non-trigger f_one_iteration while busy SHALL be ignored.
REQ-028 converged and last_iteration both high SHALL set dout_conv=1.
REQ-029 f_one_iteration with neither condition SHALL only increment iter_cnt.
REQ-030 dout_ready while dout_valid low SHALL have no effect.

Reset
REQ-031 rst high at any clock edge, including mid-frame, SHALL force IDLE, beat=0, iter_cnt=0, shadow=0, dout=0, dout_valid=0, dout_last=0, dout_iter=0, dout_conv=0, stop_decode=0, busy=0, frame_drop=0 next cycle.
REQ-032 Trigger coincident with rst SHALL be discarded.

Verification
REQ-033 Three non-terminating pulses then pulse with converged=1, v_out=word k value k, ready=1 -> stop_decode pulse, dout_iter=4, dout_conv=1, beats 0..143 carry 0..143 consecutively, dout_last on beat 143.
REQ-034 Pulse with last_iteration=1, converged=0 after 30 pulses -> dout_iter=31, dout_conv=0; 40 extra pulses before trigger -> dout_iter saturates 31.
REQ-035 dout_ready toggled randomly (incl. low for 10 cycles on beat 0 and 143) -> dout stable while stalled, exactly 144 handshakes, order preserved.
REQ-036 Second trigger during SEND beat 50 with different v_out -> frame_drop pulse, remaining beats unchanged, dout_iter unchanged.
REQ-037 rst asserted at beat 70 -> next cycle dout_valid=0, busy=0; new trigger afterwards streams full frame from beat 0 with dout_iter counted from 0.
REQ-038 v_out changed in cycle after ARM -> streamed data equals value present in ARM cycle.
